// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end.
package spi_pkg;

    localparam int unsigned CMD_W_DEF  = 10;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    typedef enum logic [1:0] {
        SHIFT_IN,
        WAIT_TX,
        SHIFT_OUT,
        DONE
    } rd_phase_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// Shifts one RAM read byte onto MISO, MSB first, one bit per cycle after load.
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              done
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;

    // MSB goes out on the load edge; done marks the cycle carrying the last bit
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            MISO  <= 1'b0;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (load) begin
            MISO  <= tx_data[DATA_W-1];
            shreg <= {tx_data[DATA_W-2:0], 1'b0};
            cnt   <= CNT_W'(DATA_W - 1);
            done  <= 1'b0;
        end else if (cnt != '0) begin
            MISO  <= shreg[DATA_W-1];
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt - CNT_W'(1);
            done  <= (cnt == CNT_W'(1));
        end else begin
            MISO <= 1'b0;
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises command words for the RAM and returns read data on MISO.
// Optional macro SPI_TX_TIMEOUT_EN adds a bounded wait for RAM read data (tx_timeout output).
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CMD_W  = CMD_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
`ifdef SPI_TX_TIMEOUT_EN
    ,
    parameter int unsigned TX_TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [CMD_W-1:0]  rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
`ifdef SPI_TX_TIMEOUT_EN
    ,
    output logic              tx_timeout
`endif
);
    localparam logic [3:0] LAST_IDX = 4'(CMD_W - 1);
    localparam logic [3:0] FULL_CNT = 4'(CMD_W);

    state_t          state, state_nx;
    rd_phase_t       phase, phase_nx;
    logic [3:0]      bit_cnt;
    logic [CMD_W-2:0] shreg;
    logic            rd_addr_seen;
    logic            in_shift;
    logic            shift_en;
    logic            last_bit;
    logic            load;
    logic            tx_done;
    logic            timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            phase <= SHIFT_IN;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        if (state != IDLE && SS_n) begin
            state_nx = IDLE;
            phase_nx = SHIFT_IN;
        end else begin
            case (state)
                IDLE: begin
                    if (!SS_n) state_nx = CHK_CMD;
                end
                CHK_CMD: begin
                    phase_nx = SHIFT_IN;
                    if (!MOSI)             state_nx = WRITE;
                    else if (rd_addr_seen) state_nx = READ_DATA;
                    else                   state_nx = READ_ADD;
                end
                READ_DATA: begin
                    case (phase)
                        // WAIT_TX starts one cycle after the strobe so a stale tx_valid is never taken
                        SHIFT_IN:  if (bit_cnt == FULL_CNT) phase_nx = WAIT_TX;
                        WAIT_TX: begin
                            if (tx_valid)         phase_nx = SHIFT_OUT;
                            else if (timeout_hit) phase_nx = DONE;
                        end
                        SHIFT_OUT: if (tx_done) phase_nx = DONE;
                        default:   ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // The 10th bit is taken even when SS_n rises on the same edge
    always_comb begin
        shift_en = 1'b0;
        in_shift = (state == WRITE) || (state == READ_ADD) ||
                   (state == READ_DATA && phase == SHIFT_IN);
        if (state == CHK_CMD)
            shift_en = !SS_n;
        else if (in_shift && bit_cnt < FULL_CNT)
            shift_en = !SS_n || (bit_cnt == LAST_IDX);
        last_bit = shift_en && (bit_cnt == LAST_IDX);
        load     = (state == READ_DATA) && (phase == WAIT_TX) && !SS_n && tx_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid <= last_bit;
            if (SS_n)
                bit_cnt <= '0;
            else if (shift_en && bit_cnt != 4'hF)
                bit_cnt <= bit_cnt + 4'd1;
            if (shift_en)
                shreg <= {shreg[CMD_W-3:0], MOSI};
            if (last_bit)
                rx_data <= {shreg, MOSI};
            if (last_bit && state == READ_ADD)
                rd_addr_seen <= 1'b1;
            else if (load || timeout_hit)
                rd_addr_seen <= 1'b0;
        end
    end

`ifdef SPI_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TX_TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt;

    assign timeout_hit = (state == READ_DATA) && (phase == WAIT_TX) && !SS_n && !tx_valid &&
                         (wait_cnt == TO_W'(TX_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            tx_timeout <= 1'b0;
        end else begin
            tx_timeout <= timeout_hit;
            if (state == READ_DATA && phase == WAIT_TX)
                wait_cnt <= wait_cnt + TO_W'(1);
            else
                wait_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (SS_n),
        .load    (load),
        .tx_data (tx_data),
        .MISO    (MISO),
        .done    (tx_done)
    );

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI slave front-end that sequences the 256x8 synchronous RAM.
- Deserialises MOSI frames into 10-bit command words and hands them to the RAM over rx_data/rx_valid.
- For read-data commands, waits for the RAM's tx_data/tx_valid and serialises the byte onto MISO.
- Sits between the SPI pins and the RAM inside the SPI wrapper. SCK is treated as the system clock.

Parameters:
- CMD_W, 10, command word width: 2-bit opcode plus payload.
- DATA_W, 8, RAM data width; number of bits shifted out on MISO.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset, sampled only on the clk rising edge.
- SS_n  in  1  slave select, active-low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first, registered.
- rx_data  out  CMD_W  command word to RAM; opcode in bits [9:8].
- rx_valid  out  1  one-cycle strobe: rx_data is new.
- tx_data  in  DATA_W  RAM read data.
- tx_valid  in  1  RAM read data valid.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; MISO=0, rx_data=0, rx_valid=0.
  - Bit counter, shift registers and rd_addr_seen flag cleared.
  - Reset mid-frame aborts with no rx_valid.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. READ_DATA has sub-phases SHIFT_IN, WAIT_TX, SHIFT_OUT, DONE.
- IDLE -> CHK_CMD when SS_n=0.
- CHK_CMD: samples MOSI as bit 9 and branches:
  - MOSI=0 -> WRITE (covers opcodes 00 and 01).
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE and READ_ADD:
  - Shift 9 further MOSI bits, bits 8..0.
  - On the edge after bit 0 is sampled: rx_data <= full 10-bit word, rx_valid=1 for exactly one cycle.
  - Then hold in state with MISO=0 until SS_n=1.
  - READ_ADD sets rd_addr_seen=1 with the rx_valid strobe.
- READ_DATA:
  - SHIFT_IN: as above (payload is don't-care); rx_valid pulse.
  - WAIT_TX: entered the cycle after the rx_valid pulse. tx_valid is ignored until then, because the RAM's tx_valid may still be set from an earlier read.
  - First cycle with tx_valid=1: latch tx_data, go to SHIFT_OUT.
  - SHIFT_OUT: drive MISO with bits 7..0 on 8 consecutive cycles, starting the cycle after the latch.
  - DONE: MISO=0; rd_addr_seen cleared.
- SS_n=1 in any state: next state IDLE, MISO=0, bit counter cleared.
  - rx_valid does not fire if fewer than 10 bits were received.
  - rd_addr_seen is retained, except when the abort happens in SHIFT_OUT or DONE (already cleared).
- Once the 10th bit is captured, the rx_valid strobe fires even if SS_n rises in that same cycle.
- rx_data holds its last value between strobes; the RAM decodes rx_data[9:8] continuously.
- Bit counter: 4 bits, saturates; no wrap.

Optional Feature:
- Macro SPI_TX_TIMEOUT_EN.
- Defined:
  - Adds parameter TX_TIMEOUT (default 16) and output port tx_timeout (1 bit).
  - If WAIT_TX lasts TX_TIMEOUT cycles without tx_valid: pulse tx_timeout for one cycle, go to DONE, MISO=0, clear rd_addr_seen.
- Undefined: WAIT_TX waits indefinitely until tx_valid or SS_n=1; no tx_timeout port.

Decomposition:
- Package spi_pkg:
  - state enum for IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; read sub-phase enum.
  - CMD_W and DATA_W defaults.
  - Opcode constants: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
- One sub-module, spi_tx_serializer:
  - Inputs: load, tx_data. Outputs: MISO, done.
  - 8-bit shift register and down-counter.

Test Plan:
- Reset check: hold rst_n=0 for 2 edges mid-frame -> MISO=0, rx_valid=0, state IDLE; an asynchronous rst_n glitch between edges has no effect.
- Write address: SS_n=0, MOSI 00_0000_1010 -> single rx_valid pulse with rx_data=10'h00A; no second pulse until SS_n cycles.
- Write data: frame 01_1010_0101 -> rx_data=10'h1A5, one pulse; RAM mem[0x0A]=0xA5.
- Read sequence: frame 10_0000_1010 -> rx_data=10'h20A; then frame 11_xxxx_xxxx -> rx_valid pulse, then MISO=1,0,1,0,0,1,0,1 (0xA5); a third frame beginning with 1 goes to READ_ADD again.
- Abort: SS_n high after 6 bits of a write frame -> no rx_valid, rx_data unchanged, next frame decodes correctly.
- Timeout (SPI_TX_TIMEOUT_EN): tx_valid forced 0 after a read-data frame -> tx_timeout pulses 16 cycles after entering WAIT_TX; MISO stays 0.
